fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the five-stage pipeline. It produces per-operand forward selects for the EX stage from the MEM and WB stages. It also detects load-use hazards against the ID stage and runs a small state machine that stalls ID and bubbles EX until the data memory completes the load. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
- NPORTS, 2, number of source-operand ports per instruction (rs, rt, ...)
- AW, 5, register address width
- CNT_W, 16, stall counter width
- ZERO_REG, 1, if 1 register 0 is hardwired zero: never forwarded, never causes a stall
- CLK  in  1  pipeline clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- id_src  in  NPORTS*AW  source registers of the instruction in ID; port k at bits [k*AW +: AW]
- ex_src  in  NPORTS*AW  source registers of the instruction in EX, same packing
- ex_rd  in  AW  destination of the instruction in EX
- ex_regwr  in  1  EX instruction writes a register
- ex_memrd  in  1  EX instruction is a load
- mem_rd  in  AW  destination in MEM
- mem_regwr  in  1  MEM instruction writes a register
- wb_rd  in  AW  destination in WB
- wb_regwr  in  1  WB instruction writes a register
- dhit  in  1  data memory completes the load currently in MEM this cycle
- forward  out  NPORTS*2  per-port select: 0 register file, 1 MEM result, 2 WB result; 3 never driven
- stall_id  out  1  hold PC and IF/ID latch
- flush_ex  out  1  insert bubble into ID/EX latch
- stall_cnt  out  CNT_W  stall cycles since reset, saturating

## Operation
- A match between an address a and stage X holds when X_regwr=1, X_rd==a, and (ZERO_REG==0 or a!=0).
- Forward selects for port k use ex_src[k]. A MEM match gives 1. Otherwise a WB match gives 2. Otherwise 0. MEM has priority over WB.
- When the MEM instruction is a load, select 1 carries load data; that mux lives upstream.
- A load-use hazard exists when ex_memrd=1 and any id_src[k] has an EX match.
- FSM states are IDLE and MEMWAIT.
- IDLE:
  - If a hazard exists: stall_id=1 and flush_ex=1; next state MEMWAIT.
  - Otherwise: stall_id=0 and flush_ex=0; stay in IDLE.
- MEMWAIT (the load is now in MEM, the dependent instruction is still held in ID):
  - dhit=0: stall_id=1, flush_ex=1; stay in MEMWAIT.
  - dhit=1: stall_id=0, flush_ex=0; next state IDLE. The dependent instruction enters EX next cycle and the load reaches WB, giving forward=2.
- MEMWAIT ignores new hazard evaluation; ID is frozen, so none can arise.
- stall_cnt increments by 1 on each rising edge where stall_id=1. It holds at 2^CNT_W-1 and does not wrap.

## Timing
- forward, stall_id and flush_ex are combinational from the inputs and current state, valid in the same cycle. These are Mealy outputs.
- Minimum stall is 1 cycle: hazard in IDLE, then dhit=1 on the first MEMWAIT cycle. Each cycle of dhit=0 adds one stall cycle.
- Reset values: state IDLE, stall_cnt=0.
- While RST=1, stall_id=0 and flush_ex=0; forward remains a pure function of the inputs.
- RST asserted in MEMWAIT returns the FSM to IDLE on the next edge and clears the counter, with no residual stall.
- A hazard and a simultaneous MEM/WB forward on another port are independent. Forward selects are always computed, including during stalls.
- If dhit=1 arrives in IDLE it has no effect.

## Test plan
- ex_src[0]=3, mem_rd=3/mem_regwr=1, wb_rd=3/wb_regwr=1 -> forward[1:0]=1. Drop mem_regwr -> forward[1:0]=2. Drop wb_regwr -> 0.
- ZERO_REG=1, ex_src[1]=0, mem_rd=0, mem_regwr=1 -> forward[3:2]=0. Same with ex_rd=0, ex_memrd=1, id_src[0]=0 -> no stall.
- Load-use: ex_rd=5, ex_memrd=1, ex_regwr=1, id_src[1]=5, dhit=1 on the next cycle -> stall_id=flush_ex=1 for exactly 1 cycle, stall_cnt=1, FSM back in IDLE.
- Same load with dhit held low 3 cycles after entry -> stall_id high 4 cycles total, stall_cnt=4.
- RST pulsed on the second MEMWAIT cycle -> stall_id=0 in the RST cycle and after, stall_cnt=0, next hazard handled normally.
- CNT_W=2, 5 consecutive stall cycles -> stall_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard unit for the five-stage pipeline.
// Forward selects are pure combinational functions of the stage addresses.
// A two-state FSM stalls ID and bubbles EX until the data memory completes
// the load that ID depends on.
// A saturating counter tracks the total number of stall cycles.
module fwd_hazard_unit #(
  parameter int NPORTS   = 2,
  parameter int AW       = 5,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NPORTS*AW-1:0] id_src,
  input  logic [NPORTS*AW-1:0] ex_src,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_regwr,
  input  logic                 ex_memrd,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_regwr,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_regwr,
  input  logic                 dhit,
  output logic [NPORTS*2-1:0]  forward,
  output logic                 stall_id,
  output logic                 flush_ex,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic {
    IDLE,
    MEMWAIT
  } state_t;

  state_t state, state_nx;
  logic   hazard;

  // Register 0 never matches when it is hardwired to zero.
  function automatic logic addr_match(input logic [AW-1:0] a,
                                      input logic [AW-1:0] rd,
                                      input logic          regwr);
    return regwr && (rd == a) && ((ZERO_REG == 0) || (a != '0));
  endfunction

  // Per-port forward select: MEM beats WB, otherwise the register file.
  always_comb begin
    forward = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (addr_match(ex_src[k*AW +: AW], mem_rd, mem_regwr))
        forward[k*2 +: 2] = 2'd1;
      else if (addr_match(ex_src[k*AW +: AW], wb_rd, wb_regwr))
        forward[k*2 +: 2] = 2'd2;
    end
  end

  // Load-use hazard: a load in EX writes a register that ID reads.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (ex_memrd && addr_match(id_src[k*AW +: AW], ex_rd, ex_regwr))
        hazard = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; MEMWAIT ignores hazards because ID is frozen.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hazard) state_nx = MEMWAIT;
      MEMWAIT: if (dhit)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Mealy stall/bubble outputs, forced low while reset is held.
  always_comb begin
    stall_id = 1'b0;
    flush_ex = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          stall_id = hazard;
          flush_ex = hazard;
        end
        MEMWAIT: begin
          stall_id = !dhit;
          flush_ex = !dhit;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles with stall_id asserted.
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt <= '0;
    else if (stall_id && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: forwarding priority, zero
// register, load-use stall lengths, reset mid-stall and counter saturation.
module tb_fwd_hazard_unit;

  localparam int NPORTS = 2;
  localparam int AW     = 5;

  logic                 CLK;
  logic                 RST;
  logic [NPORTS*AW-1:0] id_src;
  logic [NPORTS*AW-1:0] ex_src;
  logic [AW-1:0]        ex_rd;
  logic                 ex_regwr;
  logic                 ex_memrd;
  logic [AW-1:0]        mem_rd;
  logic                 mem_regwr;
  logic [AW-1:0]        wb_rd;
  logic                 wb_regwr;
  logic                 dhit;
  logic [NPORTS*2-1:0]  forward, forward2;
  logic                 stall_id, stall_id2;
  logic                 flush_ex, flush_ex2;
  logic [15:0]          stall_cnt;
  logic [1:0]           stall_cnt2;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.NPORTS(NPORTS), .AW(AW), .CNT_W(16), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .id_src(id_src), .ex_src(ex_src), .ex_rd(ex_rd),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .mem_rd(mem_rd),
    .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr), .dhit(dhit),
    .forward(forward), .stall_id(stall_id), .flush_ex(flush_ex),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.NPORTS(NPORTS), .AW(AW), .CNT_W(2), .ZERO_REG(1)) dut2 (
    .CLK(CLK), .RST(RST), .id_src(id_src), .ex_src(ex_src), .ex_rd(ex_rd),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .mem_rd(mem_rd),
    .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr), .dhit(dhit),
    .forward(forward2), .stall_id(stall_id2), .flush_ex(flush_ex2),
    .stall_cnt(stall_cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    id_src = '0; ex_src = '0; ex_rd = '0; ex_regwr = 0; ex_memrd = 0;
    mem_rd = '0; mem_regwr = 0; wb_rd = '0; wb_regwr = 0; dhit = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    step();
    RST = 0;
    #1;
  endtask

  // Load in EX writing r5, ID reads r5 on port 1.
  task automatic drive_load_hazard();
    ex_rd = 5'd5; ex_regwr = 1; ex_memrd = 1;
    id_src[AW +: AW] = 5'd5;
  endtask

  // The load moved to MEM, EX holds a bubble.
  task automatic drive_memwait();
    ex_rd = '0; ex_regwr = 0; ex_memrd = 0;
    mem_rd = 5'd5; mem_regwr = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    drive_load_hazard();
    RST = 1;
    #1;
    total++;
    if (stall_id !== 1'b0 || flush_ex !== 1'b0) begin
      bad++; $display("FAIL reset_outputs stall=%b flush=%b exp 0/0", stall_id, flush_ex);
    end
    step();
    step();
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    clear_inputs();
    RST = 0;
    #1;
    total++;
    if (stall_id !== 1'b0 || flush_ex !== 1'b0) begin
      bad++; $display("FAIL reset_idle stall=%b flush=%b exp 0/0", stall_id, flush_ex);
    end
  endtask

  task automatic test_forward();
    do_reset();
    ex_src[0 +: AW] = 5'd3;
    mem_rd = 5'd3; mem_regwr = 1; wb_rd = 5'd3; wb_regwr = 1;
    #1;
    total++;
    if (forward[1:0] !== 2'd1) begin
      bad++; $display("FAIL fwd_mem_prio got=%0d exp=1", forward[1:0]);
    end
    mem_regwr = 0;
    #1;
    total++;
    if (forward[1:0] !== 2'd2) begin
      bad++; $display("FAIL fwd_wb got=%0d exp=2", forward[1:0]);
    end
    wb_regwr = 0;
    #1;
    total++;
    if (forward[1:0] !== 2'd0) begin
      bad++; $display("FAIL fwd_none got=%0d exp=0", forward[1:0]);
    end
    // Port 1 from MEM, port 0 from WB, address mismatch ignored.
    ex_src[0 +: AW] = 5'd9; ex_src[AW +: AW] = 5'd12;
    mem_rd = 5'd12; mem_regwr = 1; wb_rd = 5'd9; wb_regwr = 1;
    #1;
    total++;
    if (forward !== 4'b0110) begin
      bad++; $display("FAIL fwd_both_ports got=%b exp=0110", forward);
    end
    wb_rd = 5'd10;
    #1;
    total++;
    if (forward !== 4'b0100) begin
      bad++; $display("FAIL fwd_addr_mismatch got=%b exp=0100", forward);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    ex_src[AW +: AW] = 5'd0; mem_rd = 5'd0; mem_regwr = 1;
    #1;
    total++;
    if (forward[3:2] !== 2'd0) begin
      bad++; $display("FAIL zero_no_fwd got=%0d exp=0", forward[3:2]);
    end
    ex_rd = 5'd0; ex_memrd = 1; ex_regwr = 1; id_src[0 +: AW] = 5'd0;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL zero_no_stall got=%b exp=0", stall_id);
    end
    step();
    total++;
    if (stall_cnt !== 16'd0 || stall_id !== 1'b0) begin
      bad++; $display("FAIL zero_no_count cnt=%0d stall=%b exp 0/0", stall_cnt, stall_id);
    end
  endtask

  task automatic test_load_use_min();
    do_reset();
    drive_load_hazard();
    ex_src[0 +: AW] = 5'd7; wb_rd = 5'd7; wb_regwr = 1;
    #1;
    total++;
    if (stall_id !== 1'b1 || flush_ex !== 1'b1 || forward[1:0] !== 2'd2) begin
      bad++; $display("FAIL lu_detect stall=%b flush=%b fwd0=%0d exp 1/1/2", stall_id, flush_ex, forward[1:0]);
    end
    step();
    drive_memwait();
    dhit = 1;
    #1;
    total++;
    if (stall_id !== 1'b0 || flush_ex !== 1'b0 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_release stall=%b flush=%b cnt=%0d exp 0/0/1", stall_id, flush_ex, stall_cnt);
    end
    step();
    // Dependent instruction in EX, load in WB; dhit in IDLE is ignored.
    clear_inputs();
    ex_src[AW +: AW] = 5'd5; wb_rd = 5'd5; wb_regwr = 1; dhit = 1;
    #1;
    total++;
    if (forward[3:2] !== 2'd2 || stall_id !== 1'b0 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_after fwd1=%0d stall=%b cnt=%0d exp 2/0/1", forward[3:2], stall_id, stall_cnt);
    end
    dhit = 0;
    step();
    total++;
    if (stall_id !== 1'b0 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_idle_hold stall=%b cnt=%0d exp 0/1", stall_id, stall_cnt);
    end
  endtask

  task automatic test_load_use_wait();
    int unsigned highs;
    do_reset();
    highs = 0;
    drive_load_hazard();
    #1;
    if (stall_id === 1'b1) highs++;
    step();
    drive_memwait();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_id === 1'b1 && flush_ex === 1'b1) highs++;
      step();
    end
    dhit = 1;
    #1;
    if (stall_id === 1'b1) highs++;
    step();
    clear_inputs();
    #1;
    if (stall_id === 1'b1) highs++;
    total++;
    if (highs !== 4) begin
      bad++; $display("FAIL wait_stall_cycles got=%0d exp=4", highs);
    end
    total++;
    if (stall_cnt !== 16'd4) begin
      bad++; $display("FAIL wait_cnt got=%0d exp=4", stall_cnt);
    end
  endtask

  task automatic test_reset_in_memwait();
    do_reset();
    drive_load_hazard();
    step();
    drive_memwait();
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL rstw_first_wait got=%b exp=1", stall_id);
    end
    step();
    RST = 1;
    #1;
    total++;
    if (stall_id !== 1'b0 || flush_ex !== 1'b0) begin
      bad++; $display("FAIL rstw_during stall=%b flush=%b exp 0/0", stall_id, flush_ex);
    end
    step();
    RST = 0;
    clear_inputs();
    #1;
    total++;
    if (stall_id !== 1'b0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rstw_after stall=%b cnt=%0d exp 0/0", stall_id, stall_cnt);
    end
    drive_load_hazard();
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL rstw_new_hazard got=%b exp=1", stall_id);
    end
    step();
    drive_memwait();
    dhit = 1;
    #1;
    total++;
    if (stall_id !== 1'b0 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL rstw_new_release stall=%b cnt=%0d exp 0/1", stall_id, stall_cnt);
    end
    step();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    drive_load_hazard();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) drive_memwait();
      total++;
      if (stall_cnt2 !== exp_cnt[i]) begin
        bad++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", i, stall_cnt2, exp_cnt[i]);
      end
    end
    total++;
    if (stall_cnt !== 16'd5) begin
      bad++; $display("FAIL sat_wide_cnt got=%0d exp=5", stall_cnt);
    end
    dhit = 1;
    step();
    clear_inputs();
    step();
    total++;
    if (stall_cnt2 !== 2'd3 || stall_id2 !== 1'b0) begin
      bad++; $display("FAIL sat_hold cnt=%0d stall=%b exp 3/0", stall_cnt2, stall_id2);
    end
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    test_reset();
    test_forward();
    test_zero_reg();
    test_load_use_min();
    test_load_use_wait();
    test_reset_in_memwait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
